// File: rtl/countdown_timer_pkg.sv
// rtl/countdown_timer_pkg.sv - shared types and constants for the countdown timer
// Purpose: state encoding, time-value width and the controller's interval selectors.
// Ports: none (package).
package countdown_timer_pkg;

  localparam int TIME_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    COUNTING = 2'b01,
    DONE     = 2'b10
  } timer_state_t;

  // Interval selectors driven by the anti-theft controller into the parameter store.
  localparam logic [1:0] ARM_DELAY       = 2'b00;
  localparam logic [1:0] DRIVER_DELAY    = 2'b01;
  localparam logic [1:0] PASSENGER_DELAY = 2'b10;
  localparam logic [1:0] ALARM_ON        = 2'b11;

endpackage

// File: rtl/countdown_timer_one_hz_divider.sv
// rtl/countdown_timer_one_hz_divider.sv - clock divider producing a one-second tick strobe
// Purpose: counts clock cycles while running and strobes tick on the last cycle of each second.
// Ports: clock, systemReset (async, active-high), clear (restart the second),
//        run (count enable), tick (high during the final cycle of a second).
module one_hz_divider #(
  parameter int CLOCKS_PER_SECOND = 1000
) (
  input  logic clock,
  input  logic systemReset,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int W = $clog2(CLOCKS_PER_SECOND);
  localparam logic [W-1:0] LAST = W'(CLOCKS_PER_SECOND - 1);

  logic [W-1:0] count;

  // Decoded from registers only, so the strobe is glitch-free within the cycle.
  assign tick = run && (count == LAST);

  // The count is held at zero whenever not running, so every second starts clean.
  always_ff @(posedge clock or posedge systemReset) begin
    if (systemReset) begin
      count <= '0;
    end else if (clear || !run || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - seconds-resolution countdown timer with held expiry flag
// Purpose: loads a 4-bit duration on startTimer, counts it down once per second,
//          and holds expired once the count reaches zero.
// Ports: clock, systemReset (async, active-high), startTimer, value[3:0] (seconds),
//        remaining[3:0], busy, expired, oneHzEnable (tick strobe while counting).
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int CLOCKS_PER_SECOND = 1000
) (
  input  logic                  clock,
  input  logic                  systemReset,
  input  logic                  startTimer,
  input  logic [TIME_WIDTH-1:0] value,
  output logic [TIME_WIDTH-1:0] remaining,
  output logic                  busy,
  output logic                  expired,
  output logic                  oneHzEnable
);

  timer_state_t          state, state_next;
  logic [TIME_WIDTH-1:0] remaining_next;
  logic                  tick;

  // A start always restarts the partial second, whatever state we were in.
  one_hz_divider #(
    .CLOCKS_PER_SECOND(CLOCKS_PER_SECOND)
  ) u_divider (
    .clock      (clock),
    .systemReset(systemReset),
    .clear      (startTimer),
    .run        (state == COUNTING),
    .tick       (tick)
  );

  always_ff @(posedge clock or posedge systemReset) begin
    if (systemReset) begin
      state     <= IDLE;
      remaining <= '0;
    end else begin
      state     <= state_next;
      remaining <= remaining_next;
    end
  end

  always_comb begin
    state_next     = state;
    remaining_next = remaining;
    if (startTimer) begin
      remaining_next = value;
      state_next     = (value != '0) ? COUNTING : DONE;
    end else begin
      case (state)
        COUNTING: begin
          if (tick) begin
            remaining_next = remaining - 1'b1;
            if (remaining == 4'd1) begin
              state_next = DONE;
            end
          end
        end
        DONE: begin
          remaining_next = '0;
        end
        default: begin
          state_next = state;
        end
      endcase
    end
  end

  assign busy        = (state == COUNTING);
  assign expired     = (state == DONE);
  assign oneHzEnable = tick;

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - scoreboard bench for countdown_timer with a time-based reference model
module tb_countdown_timer;

  localparam int N = 4;

  logic       clock;
  logic       systemReset;
  logic       startTimer;
  logic [3:0] value;
  logic [3:0] remaining;
  logic       busy;
  logic       expired;
  logic       oneHzEnable;

  typedef struct {
    logic [3:0] rem;
    logic       busy;
    logic       exp;
    logic       one;
  } exp_t;

  exp_t q[$];

  int tests;
  int fails;
  int ticks_seen;

  // Reference model: time elapsed since the last start edge, in edges.
  bit model_active;
  int model_val;
  int model_k;

  countdown_timer #(
    .CLOCKS_PER_SECOND(N)
  ) dut (
    .clock      (clock),
    .systemReset(systemReset),
    .startTimer (startTimer),
    .value      (value),
    .remaining  (remaining),
    .busy       (busy),
    .expired    (expired),
    .oneHzEnable(oneHzEnable)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic exp_t model_expect();
    exp_t e;
    int secs;
    int r;
    if (!model_active) begin
      e.rem = 4'd0; e.busy = 1'b0; e.exp = 1'b0; e.one = 1'b0;
    end else begin
      secs   = model_k / N;
      r      = (secs >= model_val) ? 0 : model_val - secs;
      e.rem  = 4'(r);
      e.busy = (model_k < model_val * N);
      e.exp  = !e.busy;
      e.one  = e.busy && ((model_k % N) == N - 1);
    end
    return e;
  endfunction

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // One clock: apply inputs, let the edge happen, advance the model, queue the expectation.
  task automatic cycle(input logic r, input logic s, input logic [3:0] v);
    systemReset = r;
    startTimer  = s;
    value       = v;
    @(posedge clock);
    if (r) begin
      model_active = 1'b0;
    end else if (s) begin
      model_active = 1'b1;
      model_val    = int'(v);
      model_k      = 0;
    end else if (model_active && model_k < 100000) begin
      model_k++;
    end
    q.push_back(model_expect());
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 4'($urandom_range(0, 15)));
  endtask

  task automatic drain();
    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clock);
    #1;
  endtask

  // Monitor: compares every sampled cycle against the queued expectation.
  always @(negedge clock) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("remaining", int'(remaining), int'(e.rem));
      check("busy", int'(busy), int'(e.busy));
      check("expired", int'(expired), int'(e.exp));
      check("oneHzEnable", int'(oneHzEnable), int'(e.one));
      if (oneHzEnable) ticks_seen++;
    end
  end

  initial begin
    tests        = 0;
    fails        = 0;
    ticks_seen   = 0;
    model_active = 1'b0;
    model_val    = 0;
    model_k      = 0;
    systemReset  = 1'b1;
    startTimer   = 1'b0;
    value        = 4'd0;

    // Reset then idle: everything stays zero.
    cycle(1'b1, 1'b0, 4'd0);
    cycle(1'b1, 1'b0, 4'd0);
    idle(20);

    // value=3 single-cycle start: 3 ticks, expiry 12 edges later, then held.
    drain(); ticks_seen = 0;
    cycle(1'b0, 1'b1, 4'd3);
    idle(22);
    drain(); check("ticks_v3", ticks_seen, 3);

    // value=0: immediate expiry, no ticks.
    ticks_seen = 0;
    cycle(1'b0, 1'b1, 4'd0);
    idle(6);
    drain(); check("ticks_v0", ticks_seen, 0);

    // value=5 then restart with value=2 six cycles later.
    cycle(1'b0, 1'b1, 4'd5);
    idle(5);
    cycle(1'b0, 1'b1, 4'd2);
    idle(12);

    // Asynchronous reset mid-count with startTimer held high.
    cycle(1'b0, 1'b1, 4'd4);
    idle(4);
    drain();
    @(negedge clock);
    #1;
    systemReset = 1'b1;
    startTimer  = 1'b1;
    value       = 4'd4;
    #1;
    check("async_rst_remaining", int'(remaining), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_expired", int'(expired), 0);
    check("async_rst_onehz", int'(oneHzEnable), 0);
    model_active = 1'b0;
    cycle(1'b1, 1'b1, 4'd4);
    cycle(1'b1, 1'b1, 4'd4);
    cycle(1'b0, 1'b1, 4'd4);
    idle(20);

    // value=15: 60 edges, 15 ticks, no wrap afterwards.
    drain(); ticks_seen = 0;
    cycle(1'b0, 1'b1, 4'd15);
    idle(70);
    drain(); check("ticks_v15", ticks_seen, 15);

    // Randomised starts, restarts and held starts.
    for (int it = 0; it < 30; it++) begin
      int hold;
      hold = $urandom_range(1, 3);
      for (int h = 0; h < hold; h++) cycle(1'b0, 1'b1, 4'($urandom_range(0, 15)));
      idle($urandom_range(0, 70));
    end

    drain();
    check("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Seconds-resolution countdown timer for the anti-theft controller, directly downstream of the time-parameter store. The controller FSM selects an interval, and the store presents the programmed 4-bit duration on `value`. On `startTimer`, this block loads that duration, counts it down in one-second steps from an internal clock divider, and raises `expired` when the count reaches zero. `expired` stays high until the next start or reset.

## Interface
- `CLOCKS_PER_SECOND`, default 1000: clock cycles per one-second tick; must be ≥ 2; benches override it to 4.
- `clock`, input, 1: single system clock; all state updates on the rising edge.
- `systemReset`, input, 1: asynchronous, active-high reset.
- `startTimer`, input, 1: sampled each rising edge; when high, (re)loads `value` and starts counting.
- `value`, input, 4: duration in seconds, 0–15, from the time-parameter store.
- `remaining`, output, 4: seconds left in the current count.
- `busy`, output, 1: high while counting.
- `expired`, output, 1: high once the count has reached zero; held.
- `oneHzEnable`, output, 1: one-cycle tick strobe, active only while counting.

## Operation
- States: IDLE, COUNTING, DONE.
- Reset state: IDLE, with `remaining`=0, divider=0, `busy`=0, `expired`=0, `oneHzEnable`=0.
- `startTimer` high at an edge, from any state (highest priority after reset):
  - `remaining` ← `value`, divider ← 0.
  - Next state is COUNTING if `value`≠0, otherwise DONE.
- COUNTING:
  - Divider increments every edge.
  - `oneHzEnable` = (divider == `CLOCKS_PER_SECOND`−1), decoded combinationally from registers.
  - On a tick edge: divider ← 0 and `remaining` decrements.
  - If `remaining` is 1 at a tick, it becomes 0 and the state moves to DONE.
- DONE:
  - `expired`=1, `busy`=0, divider held at 0, `remaining` held at 0.
  - Stays in DONE until `startTimer` or reset.
- IDLE and DONE: divider held at 0, `oneHzEnable`=0.
- `busy` = (state == COUNTING). `expired` = (state == DONE).
- `startTimer` held high for several cycles reloads on every such edge; the count effectively begins at the last high edge.
- `remaining` never wraps: no decrement below 0, and no tick outside COUNTING.
- `value` is only sampled on start edges; changes at other times have no effect.

## Timing
- Let the start edge be E0 and N = `CLOCKS_PER_SECOND`.
  - `busy` rises after E0.
  - Ticks occur at E0+kN.
  - `oneHzEnable` is high during the cycle preceding each such edge.
  - `expired` rises after edge E0+`value`·N and `busy` falls after that same edge.
- For `value`=0, `expired` rises after E0 and no tick ever occurs.
- A restart during COUNTING discards the old count and any partially elapsed second; the next tick follows N edges later.
- Reset takes effect immediately, without waiting for a clock edge. All outputs go to their reset values while `systemReset` is high, and `startTimer` is ignored during that time. The first start is sampled at the first edge after deassertion.

## Structure
- Shared package contents:
  - State encoding (IDLE=2'b00, COUNTING=2'b01, DONE=2'b10).
  - Interval-selector constants used by the controller FSM: ARM_DELAY=2'b00, DRIVER_DELAY=2'b01, PASSENGER_DELAY=2'b10, ALARM_ON=2'b11.
  - Time-value width, 4.
- One sub-module, `one_hz_divider`:
  - Inputs: `clock`, `systemReset`, `clear`, `run`. Output: `tick`.
  - Counter width $clog2(`CLOCKS_PER_SECOND`), parameterised identically.
- `countdown_timer` contains the state machine and the `remaining` register.

## Test plan
All scenarios use `CLOCKS_PER_SECOND`=4.
- Reset, then 20 idle cycles → `remaining`=0, `busy`=0, `expired`=0, and `oneHzEnable` never high.
- `value`=3, `startTimer` pulsed for one cycle → `remaining` steps 3,2,1,0 at 4-cycle intervals, 3 ticks in total. `expired` rises exactly 12 edges after the start edge and holds for 10 further cycles.
- `value`=0 start → `expired`=1 after the next edge, `busy` never high, no ticks.
- `value`=5 start, then `value`=2 start 6 cycles later → `remaining`=2 immediately, divider cleared, `expired` rises 8 edges after the second start.
- Reset asserted between edges 5 cycles into a `value`=4 count, with `startTimer` held high during reset → all outputs 0 before the next edge. The count restarts only after deassertion.
- `value`=15 start → `expired` after exactly 60 edges, 15 ticks, and `remaining` never wraps to 15 after reaching 0.
